subtrator_serial: RTL and testbench
===================================

# subtrator_serial

Bit-serial N-bit subtractor: loads two operands plus an initial borrow, computes `a - b - bin` one bit per clock, LSB first, with a registered full-subtractor cell and a borrow flip-flop. It is the subtract-side counterpart to the full-adder cells in the adder/subtractor library. It serves datapaths that trade latency for area.

## Interface
- `LARGURA`, default 8: operand and result width in bits; must be at least 2.

- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `inicio` in 1: start request; sampled only in OCIOSO.
- `a` in LARGURA: minuend; captured on the accepting edge.
- `b` in LARGURA: subtrahend; captured on the accepting edge.
- `bin` in 1: initial borrow; captured on the accepting edge.
- `ocupado` out 1: high whenever state is not OCIOSO.
- `pronto` out 1: one-cycle pulse in FIM.
- `d` out LARGURA: registered difference; holds the last result until the next FIM.
- `bout` out 1: final borrow; registered with `d`.
- `d_serial` out 1: difference bit computed in the current CALCULA cycle; 0 otherwise.
- `overflow` out 1: signed overflow; this port exists only with `SUBTRATOR_SERIAL_OVERFLOW_EN`.

## Operation
- FSM states: OCIOSO, CALCULA and FIM.
- **OCIOSO**
  - If `inicio`=1: load shift registers with `a` and `b`, load the borrow flop with `bin`, clear the bit counter, and go to CALCULA.
  - Otherwise stay in OCIOSO.
- **CALCULA**, each cycle:
  - Take bit i = LSB of each operand shift register.
  - `di = ai ^ bi ^ br`.
  - `br_next = (~ai & bi) | (~(ai ^ bi) & br)`.
  - Shift `di` into the MSB of the internal result register (right shift).
  - Shift the operand registers right and increment the counter.
  - After LARGURA bits, go to FIM.
- **FIM**
  - Copy the internal result to `d` and the borrow flop to `bout` on the CALCULA-to-FIM edge.
  - Assert `pronto` for this one cycle.
  - Next edge: go to OCIOSO unconditionally.
- **Arithmetic**
  - `d = (a - b - bin) mod 2^LARGURA`.
  - `bout = 1` iff `a < b + bin` (unsigned comparison).
- **Boundary rules**
  - `inicio` in CALCULA or FIM is ignored, not queued.
  - Changes on `a`, `b` and `bin` after the accepting edge have no effect.
  - Reset at any point, including mid-operation: the operation is discarded; state goes to OCIOSO and all outputs go to 0.
- **Reset values**: `ocupado`=0, `pronto`=0, `d`=0, `bout`=0, `d_serial`=0, `overflow`=0.

## Timing
- Edge E0 accepts `inicio`. `ocupado` rises after E0.
- Edges E1..E_LARGURA each process one bit. `d_serial` during the cycle before edge Ek is bit k-1.
- After E_LARGURA:
  - state is FIM;
  - `pronto`=1, and `d`, `bout` (and `overflow`) are valid.
- After E_LARGURA+1:
  - state is OCIOSO and `ocupado` falls;
  - a new `inicio` is accepted at the edge E_LARGURA+2 at the earliest.
- Latency is LARGURA+1 cycles from the accepting edge to the `pronto` cycle. Throughput is one result per LARGURA+2 cycles.

## Configuration
- `SUBTRATOR_SERIAL_OVERFLOW_EN` defined:
  - adds the `overflow` port and a flop capturing `a[MSB]`;
  - `overflow = (a[MSB] != b[MSB]) && (d[MSB] != a[MSB])`, registered with `d` in FIM;
  - `overflow` holds its value with `d` and resets to 0.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Assert `rst_n`=0 with random inputs -> all outputs 0, state OCIOSO, `inicio` ignored while reset is held.
- LARGURA=8, `a`=8'd100, `b`=8'd58, `bin`=0 -> `d`=8'd42, `bout`=0, `pronto` high for exactly one cycle, 8 edges after the accepting edge.
- `a`=8'h05, `b`=8'h07, `bin`=0 -> `d_serial` sequence 0,1,1,1,1,1,1,1, `d`=8'hFE, `bout`=1.
- Borrow and overflow cases:
  - `a`=0, `b`=0, `bin`=1 -> `d`=8'hFF, `bout`=1.
  - With the macro, `a`=8'h80, `b`=8'h01, `bin`=0 -> `d`=8'h7F, `overflow`=1, `bout`=0.
- Hold `inicio` high continuously with `a`=8'd9, `b`=8'd3 -> results 8'd6 at 10-cycle spacing; no restart during CALCULA or FIM.
- Drop `rst_n` after the 4th CALCULA edge -> outputs 0 immediately, `pronto` never pulses. A following run of `a`=8'd200, `b`=8'd1 gives `d`=8'd199.

Source files
------------

// File: rtl/subtrator_serial.sv
// Bit-serial N-bit subtractor: d = a - b - bin, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SUBTRATOR_SERIAL_OVERFLOW_EN.
module subtrator_serial #(
  parameter int unsigned LARGURA = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inicio,
  input  logic [LARGURA-1:0] a,
  input  logic [LARGURA-1:0] b,
  input  logic               bin,
  output logic               ocupado,
  output logic               pronto,
  output logic [LARGURA-1:0] d,
  output logic               bout,
  output logic               d_serial
`ifdef SUBTRATOR_SERIAL_OVERFLOW_EN
  ,
  output logic               overflow
`endif
);

  localparam int unsigned CW = (LARGURA > 2) ? $clog2(LARGURA) : 1;

  typedef enum logic [1:0] {
    StOcioso,
    StCalcula,
    StFim
  } estado_t;

  estado_t            estado_q, estado_d;
  logic [LARGURA-1:0] op_a_q, op_b_q, acc_q, d_q;
  logic               br_q, bout_q;
  logic [CW-1:0]      cnt_q;

  logic ai, bi, di, br_next, ultimo;

`ifdef SUBTRATOR_SERIAL_OVERFLOW_EN
  logic a_msb_q, ovf_q;
`endif

  // Full-subtractor cell on the current LSBs and the borrow flop.
  always_comb begin
    ai      = op_a_q[0];
    bi      = op_b_q[0];
    di      = ai ^ bi ^ br_q;
    br_next = (~ai & bi) | (~(ai ^ bi) & br_q);
    ultimo  = (cnt_q == CW'(LARGURA - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= StOcioso;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Next-state logic; inicio is only looked at while idle.
  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      StOcioso:  if (inicio) estado_d = StCalcula;
      StCalcula: if (ultimo) estado_d = StFim;
      StFim:     estado_d = StOcioso;
      default:   estado_d = StOcioso;
    endcase
  end

  // Operand shift registers, borrow flop, bit counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q <= '0;
      op_b_q <= '0;
      acc_q  <= '0;
      d_q    <= '0;
      br_q   <= 1'b0;
      bout_q <= 1'b0;
      cnt_q  <= '0;
`ifdef SUBTRATOR_SERIAL_OVERFLOW_EN
      a_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (estado_q)
        StOcioso: begin
          if (inicio) begin
            op_a_q <= a;
            op_b_q <= b;
            br_q   <= bin;
            cnt_q  <= '0;
`ifdef SUBTRATOR_SERIAL_OVERFLOW_EN
            a_msb_q <= a[LARGURA-1];
`endif
          end
        end
        StCalcula: begin
          op_a_q <= op_a_q >> 1;
          op_b_q <= op_b_q >> 1;
          br_q   <= br_next;
          acc_q  <= {di, acc_q[LARGURA-1:1]};
          cnt_q  <= cnt_q + CW'(1);
          // Last bit: publish the full result together with the final borrow.
          if (ultimo) begin
            d_q    <= {di, acc_q[LARGURA-1:1]};
            bout_q <= br_next;
`ifdef SUBTRATOR_SERIAL_OVERFLOW_EN
            // On the last bit bi is b[MSB] and di is d[MSB].
            ovf_q <= (a_msb_q != bi) && (di != a_msb_q);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and registered results.
  always_comb begin
    ocupado  = (estado_q != StOcioso);
    pronto   = (estado_q == StFim);
    d_serial = (estado_q == StCalcula) & di;
    d        = d_q;
    bout     = bout_q;
`ifdef SUBTRATOR_SERIAL_OVERFLOW_EN
    overflow = ovf_q;
`endif
  end

endmodule

// File: tb/tb_subtrator_serial.sv
// Self-checking bench for subtrator_serial: scoreboard queue filled by the
// driver, drained by a monitor on every pronto pulse.
module tb_subtrator_serial;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         inicio;
  logic [W-1:0] a, b;
  logic         bin;
  logic         ocupado, pronto, bout, d_serial;
  logic [W-1:0] d;
`ifdef SUBTRATOR_SERIAL_OVERFLOW_EN
  logic         overflow;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bout;
    logic         ov;
  } exp_t;

  exp_t sb[$];

  subtrator_serial #(.LARGURA(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inicio   (inicio),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .ocupado  (ocupado),
    .pronto   (pronto),
    .d        (d),
    .bout     (bout),
    .d_serial (d_serial)
`ifdef SUBTRATOR_SERIAL_OVERFLOW_EN
    ,
    .overflow (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: plain integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tbin);
    exp_t e;
    int   diff;
    diff   = int'(ta) - int'(tb) - int'(tbin);
    e.d    = W'(diff);
    e.bout = (int'(ta) < int'(tb) + int'(tbin));
    e.ov   = (ta[W-1] != tb[W-1]) && (e.d[W-1] != ta[W-1]);
    return e;
  endfunction

  // Monitor: every pronto pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && pronto) begin
      if (sb.size() == 0) begin
        check("unexpected_pronto", 32'(pronto), 32'(0));
      end else begin
        e = sb.pop_front();
        check("result_d", 32'(d), 32'(e.d));
        check("result_bout", 32'(bout), 32'(e.bout));
`ifdef SUBTRATOR_SERIAL_OVERFLOW_EN
        check("result_overflow", 32'(overflow), 32'(e.ov));
`endif
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ocupado"}, 32'(ocupado), 32'(0));
    check({tag, "_pronto"}, 32'(pronto), 32'(0));
    check({tag, "_d"}, 32'(d), 32'(0));
    check({tag, "_bout"}, 32'(bout), 32'(0));
    check({tag, "_d_serial"}, 32'(d_serial), 32'(0));
`ifdef SUBTRATOR_SERIAL_OVERFLOW_EN
    check({tag, "_overflow"}, 32'(overflow), 32'(0));
`endif
  endtask

  // One complete operation, started and ended at a falling edge while idle.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
    exp_t e;
    e      = model(ta, tb, tbin);
    a      = ta;
    b      = tb;
    bin    = tbin;
    inicio = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(e);
    inicio = 1'b0;
    a      = W'($urandom);
    b      = W'($urandom);
    bin    = 1'($urandom);
    for (int k = 0; k < int'(W); k++) begin
      @(negedge clk);
      check("calc_ocupado", 32'(ocupado), 32'(1));
      check("calc_pronto", 32'(pronto), 32'(0));
      check("d_serial_bit", 32'(d_serial), 32'(e.d[k]));
      @(posedge clk);
    end
    @(negedge clk);
    check("pronto_timing", 32'(pronto), 32'(1));
    @(posedge clk);
    @(negedge clk);
    check("pronto_one_cycle", 32'(pronto), 32'(0));
    check("idle_ocupado", 32'(ocupado), 32'(0));
    check("d_hold", 32'(d), 32'(e.d));
    check("bout_hold", 32'(bout), 32'(e.bout));
  endtask

  initial begin
    rst_n  = 1'b0;
    inicio = 1'b0;
    a      = '0;
    b      = '0;
    bin    = 1'b0;

    // Reset held with random inputs and inicio asserted.
    for (int i = 0; i < 4; i++) begin
      inicio = 1'b1;
      a      = W'($urandom);
      b      = W'($urandom);
      bin    = 1'($urandom);
      @(negedge clk);
      check_all_zero("reset_hold");
    end
    inicio = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_op(8'd100, 8'd58, 1'b0);
    run_op(8'h05, 8'h07, 1'b0);
    run_op(8'h00, 8'h00, 1'b1);
    run_op(8'h80, 8'h01, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1);
    run_op(8'h7F, 8'hFF, 1'b0);

    // inicio held high: back-to-back results, one per W+2 cycles.
    a      = 8'd9;
    b      = 8'd3;
    bin    = 1'b0;
    inicio = 1'b1;
    @(posedge clk);
    for (int r = 0; r < 3; r++) begin
      sb.push_back(model(8'd9, 8'd3, 1'b0));
      repeat (W) @(posedge clk);
      @(negedge clk);
      check("held_pronto", 32'(pronto), 32'(1));
      @(posedge clk);
      @(negedge clk);
      check("held_idle", 32'(ocupado), 32'(0));
      check("held_no_pronto", 32'(pronto), 32'(0));
      @(posedge clk);
    end
    #1;
    inicio = 1'b0;
    @(negedge clk);
    // Let the run started by the last held edge finish.
    sb.push_back(model(8'd9, 8'd3, 1'b0));
    repeat (W + 2) @(negedge clk);
    check("held_drain_idle", 32'(ocupado), 32'(0));

    // Mid-operation reset after the 4th calculation edge.
    a      = 8'd77;
    b      = 8'd12;
    inicio = 1'b1;
    @(posedge clk);
    #1;
    inicio = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    repeat (2) begin
      inicio = 1'b1;
      @(negedge clk);
      check("mid_reset_ignored", 32'(ocupado), 32'(0));
    end
    inicio = 1'b0;
    rst_n  = 1'b1;
    repeat (W + 3) @(negedge clk);
    check("no_pronto_after_reset", 32'(ocupado), 32'(0));
    run_op(8'd200, 8'd1, 1'b0);

    // Randomized operations with random idle gaps.
    for (int i = 0; i < 30; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
